// File: rtl/piezo_echo_receiver.sv
// Piezo echo receiver: qualifies comparator pulses, timestamps them against
// a timebase zeroed at arm, and queues timestamps for Avalon readout.
`timescale 1ns/1ps
module piezo_echo_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_PULSE      = 8,
  parameter int BLANK_CYCLES   = 7000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        piezo_interface_in,
  input  logic        arm,
  output logic        echo_valid,
  output logic        busy,
  input  logic [15:0] avalon_slave_address,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  output logic        avalon_slave_waitrequest
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LISTEN  = 2'd1,
    QUALIFY = 2'd2,
    BLANK   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [31:0] tb_q, tb_d;
  logic [31:0] cand_q, cand_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] rej_q, rej_d;
  logic        ovf_q, ovf_d;
  logic        tout_q, tout_d;
  logic        echo_q, echo_d;
  logic        rd_ph_q, rd_ph_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [31:0] mem_q [FIFO_DEPTH];

  logic [15:0] sel;
  logic sig_s, go_arm, wr_clr, wr_abort, at_limit;
  logic width_hit, blank_done, qual_done, fast_hit;
  logic push, pop, full, do_wr, reject, rd_first;
  logic [31:0] push_ts;

  assign sel      = avalon_slave_address >> 8;
  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], piezo_interface_in};
  assign go_arm   = arm | (avalon_slave_write && sel == 16'h0
                           && avalon_slave_writedata != 32'h0);
  assign wr_clr   = avalon_slave_write && sel == 16'h2;
  assign wr_abort = avalon_slave_write && sel == 16'h3;
  assign at_limit = state_q != IDLE
                    && tb_q == 32'(TIMEOUT_CYCLES - 1);

  assign width_hit  = cnt_q + 32'd1 == 32'(MIN_PULSE);
  assign blank_done = cnt_q == 32'(BLANK_CYCLES - 1);
  assign qual_done  = state_q == QUALIFY && sig_s && width_hit;
  assign fast_hit   = state_q == LISTEN && sig_s && MIN_PULSE == 1;
  // A restart or abort in the same cycle discards the candidate.
  assign push    = (qual_done | fast_hit) && !go_arm && !wr_abort;
  assign push_ts = fast_hit ? tb_q : cand_q;
  assign reject  = state_q == QUALIFY && !sig_s && !go_arm && !wr_abort;

  assign rd_first = avalon_slave_read && !rd_ph_q;
  assign full     = fcnt_q == CW'(FIFO_DEPTH);
  assign pop      = rd_first && sel == 16'h0 && fcnt_q != '0;
  assign do_wr    = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_arm) state_d = LISTEN;
      LISTEN:
        if (sig_s) begin
          if (MIN_PULSE == 1) state_d = BLANK;
          else                state_d = QUALIFY;
        end
      QUALIFY:
        if (!sig_s)         state_d = LISTEN;
        else if (width_hit) state_d = BLANK;
      BLANK:   if (blank_done) state_d = LISTEN;
    endcase
    if (at_limit) state_d = IDLE;
    if (go_arm)   state_d = LISTEN;
    if (wr_abort) state_d = IDLE;
  end

  always_comb begin
    tb_d = tb_q;
    if (state_q != IDLE) tb_d = tb_q + 32'd1;
    if (go_arm)          tb_d = '0;

    cnt_d  = cnt_q;
    cand_d = cand_q;
    unique case (state_q)
      LISTEN:
        if (sig_s) begin
          cand_d = tb_q;
          cnt_d  = 32'd1;
        end
      QUALIFY: if (sig_s) cnt_d = cnt_q + 32'd1;
      BLANK:   cnt_d = cnt_q + 32'd1;
      default: ;
    endcase
    if (push) cnt_d = '0;

    rej_d = rej_q;
    if (wr_clr) rej_d = '0;
    if (reject && rej_d != 16'hFFFF) rej_d = rej_d + 16'd1;

    ovf_d = ovf_q;
    if (wr_clr) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;

    tout_d = tout_q;
    if (wr_clr)   tout_d = 1'b0;
    if (at_limit) tout_d = 1'b1;
    if (go_arm)   tout_d = 1'b0;

    last_d = push ? push_ts : last_q;
    echo_d = push;

    wp_d   = do_wr ? wp_q + AW'(1) : wp_q;
    rp_d   = pop ? rp_q + AW'(1) : rp_q;
    fcnt_d = fcnt_q + CW'(do_wr) - CW'(pop);

    rd_ph_d = rd_first;
    rdata_d = rdata_q;
    if (rd_first) begin
      unique case (1'b1)
        sel == 16'h0:
          rdata_d = fcnt_q != '0 ? mem_q[rp_q] : 32'h0;
        sel == 16'h1:
          rdata_d = {1'b0, rej_q, 8'(fcnt_q), 3'b000,
                     ovf_q, tout_q, state_q};
        sel == 16'h2:
          rdata_d = last_q;
        default:
          rdata_d = 32'hDEADBEEF;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      tb_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      rdata_q <= '0;
      rej_q   <= '0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
      echo_q  <= 1'b0;
      rd_ph_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      tb_q    <= tb_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      rej_q   <= rej_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
      echo_q  <= echo_d;
      rd_ph_q <= rd_ph_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wp_q] <= push_ts;
  end

  always_comb begin
    busy                     = state_q != IDLE;
    echo_valid               = echo_q;
    avalon_slave_readdata    = rdata_q;
    avalon_slave_waitrequest = avalon_slave_read && !rd_ph_q;
  end

endmodule

// File: tb/tb_piezo_echo_receiver.sv
// Directed bench for piezo_echo_receiver: detection, blanking, FIFO,
// timeout, abort and reset behaviour with hand-derived expectations.
`timescale 1ns/1ps
module tb_piezo_echo_receiver;

  localparam int SYNC  = 2;
  localparam int MINP  = 8;
  localparam int BLANK = 700;
  localparam int TOUT  = 4000;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        piezo;
  logic        arm;
  logic        echo_valid;
  logic        busy;
  logic [15:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic        read;
  logic [31:0] rdata;
  logic        waitreq;

  int ntests   = 0;
  int nfail    = 0;
  int echo_cnt = 0;

  always #5 clock = ~clock;

  always @(negedge clock) if (echo_valid) echo_cnt++;

  piezo_echo_receiver #(
    .SYNC_STAGES(SYNC),
    .MIN_PULSE(MINP),
    .BLANK_CYCLES(BLANK),
    .TIMEOUT_CYCLES(TOUT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .piezo_interface_in(piezo),
    .arm(arm),
    .echo_valid(echo_valid),
    .busy(busy),
    .avalon_slave_address(addr),
    .avalon_slave_write(write),
    .avalon_slave_writedata(wdata),
    .avalon_slave_read(read),
    .avalon_slave_readdata(rdata),
    .avalon_slave_waitrequest(waitreq)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] sel, output logic [31:0] d,
                    output logic w1, output logic w2);
    addr = {sel, 8'h00};
    read = 1'b1;
    #1;
    w1 = waitreq;
    tick();
    w2 = waitreq;
    d  = rdata;
    read = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [7:0] sel, input logic [31:0] v);
    addr  = {sel, 8'h00};
    wdata = v;
    write = 1'b1;
    tick();
    write = 1'b0;
    wdata = '0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse(input int n);
    piezo = 1'b1;
    repeat (n) tick();
    piezo = 1'b0;
  endtask

  logic [31:0] s, d;
  logic        w1, w2;
  int          e0;

  initial begin
    reset = 1'b1;
    piezo = 1'b0;
    arm   = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_echo", echo_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wait", waitreq, 0);
    reset = 1'b0;
    tick();
    rd(8'h01, s, w1, w2);
    chk("rst_status", s, 0);

    // Echo rising after edge A+k is stamped k+SYNC.
    e0 = echo_cnt;
    do_arm();
    chk("t1_busy", busy, 1);
    repeat (2999) tick();
    pulse(20);
    repeat (10) tick();
    chk("t1_echo_pulses", echo_cnt - e0, 1);
    rd(8'h01, s, w1, w2);
    chk("t1_count", 32'(s[14:7]), 1);
    rd(8'h00, d, w1, w2);
    chk("t1_wait_first", w1, 1);
    chk("t1_wait_second", w2, 0);
    chk("t1_ts_window",
        (d >= 3000 + SYNC - 1 && d <= 3000 + SYNC + 1), 1);
    rd(8'h00, d, w1, w2);
    chk("t1_empty_read", d, 0);
    rd(8'h02, d, w1, w2);
    chk("t1_peek_window",
        (d >= 3000 + SYNC - 1 && d <= 3000 + SYNC + 1), 1);
    rd(8'h05, d, w1, w2);
    chk("t1_bad_reg", d, 32'hDEADBEEF);

    e0 = echo_cnt;
    wr(8'h00, 32'h1);
    repeat (10) tick();
    pulse(5);
    repeat (10) tick();
    rd(8'h01, s, w1, w2);
    chk("t2_reject", 32'(s[30:15]), 1);
    chk("t2_no_push", 32'(s[14:7]), 0);
    pulse(10);
    repeat (10) tick();
    chk("t2_echo_pulses", echo_cnt - e0, 1);
    rd(8'h00, d, w1, w2);
    chk("t2_ts", d, 27 + SYNC);

    e0 = echo_cnt;
    do_arm();
    repeat (10) tick();
    pulse(20);
    repeat (380) tick();
    pulse(20);
    repeat (480) tick();
    pulse(20);
    repeat (10) tick();
    chk("t3_echo_pulses", echo_cnt - e0, 2);
    rd(8'h01, s, w1, w2);
    chk("t3_count", 32'(s[14:7]), 2);
    rd(8'h00, d, w1, w2);
    chk("t3_ts_first", d, 10 + SYNC);
    rd(8'h00, d, w1, w2);
    chk("t3_ts_second", d, 910 + SYNC);

    for (int i = 0; i < 9; i++) begin
      do_arm();
      repeat (5 + i) tick();
      pulse(10);
      repeat (5) tick();
    end
    rd(8'h01, s, w1, w2);
    chk("t4_count_full", 32'(s[14:7]), DEPTH);
    chk("t4_overflow", 32'(s[3]), 1);
    wr(8'h02, 32'h0);
    rd(8'h01, s, w1, w2);
    chk("t4_ovf_cleared", 32'(s[3]), 0);
    chk("t4_rej_cleared", 32'(s[30:15]), 0);
    chk("t4_count_kept", 32'(s[14:7]), DEPTH);
    // Push lands on the same edge as the pop of a full FIFO.
    do_arm();
    repeat (5) tick();
    piezo = 1'b1;
    repeat (9) tick();
    addr = 16'h0000;
    read = 1'b1;
    tick();
    d    = rdata;
    read = 1'b0;
    tick();
    piezo = 1'b0;
    repeat (5) tick();
    chk("t4_head_first", d, 5 + SYNC);
    rd(8'h01, s, w1, w2);
    chk("t4_pushpop_count", 32'(s[14:7]), DEPTH);
    chk("t4_pushpop_noovf", 32'(s[3]), 0);
    rd(8'h00, d, w1, w2);
    chk("t4_next_head", d, 6 + SYNC);

    do_arm();
    repeat (TOUT - 1) tick();
    chk("t5_busy_before", busy, 1);
    tick();
    chk("t5_busy_after", busy, 0);
    rd(8'h01, s, w1, w2);
    chk("t5_timeout", 32'(s[2]), 1);
    chk("t5_state", 32'(s[1:0]), 0);
    do_arm();
    repeat (TOUT / 2 - 1) tick();
    do_arm();
    rd(8'h01, s, w1, w2);
    chk("t5_rearm_tout_clr", 32'(s[2]), 0);
    repeat (TOUT - 3) tick();
    chk("t5_rearm_busy", busy, 1);
    tick();
    chk("t5_rearm_idle", busy, 0);

    do_arm();
    repeat (5) tick();
    chk("abort_busy_before", busy, 1);
    wr(8'h03, 32'h0);
    chk("abort_busy_after", busy, 0);

    rd(8'h02, d, w1, w2);
    chk("t6_last", d, 5 + SYNC);
    do_arm();
    repeat (5) tick();
    piezo = 1'b1;
    repeat (4) tick();
    chk("t6_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdata", rdata, 0);
    chk("t6_rst_echo", echo_valid, 0);
    reset = 1'b0;
    piezo = 1'b0;
    tick();
    rd(8'h01, s, w1, w2);
    chk("t6_status", s, 0);
    rd(8'h00, d, w1, w2);
    chk("t6_fifo_empty", d, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
